fetch_unit: RTL

Instruction fetch stage: holds the program counter, issues one-cycle-latency reads to instruction memory and presents fetched words to decode through a registered IF/ID interface with a valid bit. It sits directly upstream of the address adder. `pc_plus1_o` drives the adder's base operand, and the adder's sum comes back here as `branch_target_i`. The stage handles decode back-pressure (stall) and taken-branch redirect with flush.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_skid.sv | 29 ++
 rtl/fetch_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch stage.
// DSIZE and PC_SIZE normally come from the defines shared with the address adder; the fallbacks here keep this slice standalone.
`ifndef DSIZE
`define DSIZE 16
`endif
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

package fetch_unit_pkg;

    localparam int unsigned FETCH_AW = `PC_SIZE;
    localparam int unsigned FETCH_DW = `DSIZE;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_FLUSH,
        IFID_LOAD,
        IFID_BUBBLE
    } ifid_op_e;

    // IF/ID update: a redirect flushes, a stall holds, otherwise load or bubble.
    function automatic ifid_op_e ifid_op(input logic branch, input logic stall, input logic avail);
        if (branch) return IFID_FLUSH;
        if (stall)  return IFID_HOLD;
        if (avail)  return IFID_LOAD;
        return IFID_BUBBLE;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer: captures a word that returns while decode is stalled.
module fetch_skid #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         capture,
    input  logic         drain,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-cycle-latency imem reads, registered IF/ID with stall and branch flush.
// Define FETCH_SKID_EN to hold a word returning under stall in a skid buffer instead of replaying its fetch.
`ifndef DSIZE
`define DSIZE 16
`endif

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   DW       = `DSIZE,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          branch_taken_i,
    input  logic [AW-1:0] branch_target_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic [DW-1:0] imem_rdata_i,
    output logic          instr_valid_o,
    output logic [DW-1:0] instr_o,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] pc_plus1_o
);

    logic [AW-1:0]    pc_q;
    logic [AW-1:0]    fpc_q;
    logic             inflight_q;
    logic             ret_stalled;
    logic             skid_valid;
    logic [DW+AW-1:0] skid_q;
    logic [DW-1:0]    load_instr;
    logic [AW-1:0]    load_pc;
    ifid_op_e         op;

    assign imem_addr_o = branch_taken_i ? branch_target_i : pc_q;
    assign imem_req_o  = rst_n & (branch_taken_i | ~stall_i);
    assign ret_stalled = inflight_q & stall_i & ~branch_taken_i;

`ifdef FETCH_SKID_EN
    fetch_skid #(.W(DW + AW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (ret_stalled),
        .drain   (~stall_i),
        .flush   (branch_taken_i),
        .din     ({imem_rdata_i, fpc_q}),
        .valid   (skid_valid),
        .dout    (skid_q)
    );
`else
    assign skid_valid = 1'b0;
    assign skid_q     = '0;
`endif

    // PC and in-flight tracking; without a skid buffer a stalled return is refetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            fpc_q      <= '0;
            inflight_q <= 1'b0;
        end else if (imem_req_o) begin
            pc_q       <= imem_addr_o + AW'(1);
            fpc_q      <= imem_addr_o;
            inflight_q <= 1'b1;
        end else begin
            inflight_q <= 1'b0;
`ifndef FETCH_SKID_EN
            if (ret_stalled) pc_q <= fpc_q;
`endif
        end
    end

    // A buffered word is older than anything in flight, so it loads first.
    always_comb begin
        load_instr = imem_rdata_i;
        load_pc    = fpc_q;
        op         = ifid_op(branch_taken_i, stall_i, skid_valid | inflight_q);
        if (skid_valid) begin
            load_instr = skid_q[DW+AW-1:AW];
            load_pc    = skid_q[AW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            pc_o          <= '0;
            pc_plus1_o    <= AW'(1);
        end else begin
            case (op)
                IFID_LOAD: begin
                    instr_valid_o <= 1'b1;
                    instr_o       <= load_instr;
                    pc_o          <= load_pc;
                    pc_plus1_o    <= load_pc + AW'(1);
                end
                IFID_FLUSH, IFID_BUBBLE: instr_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
